// File: rtl/nt_subckt_test_seq_if.sv
// Control/observation bus between the screening sequencer and its driver.
// Carries the start/golden request side and the stimulus/result side.
interface nt_subckt_test_seq_if #(
    parameter int NIN   = 4,
    parameter int SIG_W = 16,
    parameter int NVEC  = 16
);
    localparam int VW = $clog2(NVEC + 1);

    logic             start;
    logic [SIG_W-1:0] golden_sig;
    logic             dut_out;
    logic [NIN-1:0]   dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] sig;
    logic [VW-1:0]    vec_idx;

    modport master (
        output start, golden_sig, dut_out,
        input  dut_in, busy, done, pass, sig, vec_idx
    );

    modport slave (
        input  start, golden_sig, dut_out,
        output dut_in, busy, done, pass, sig, vec_idx
    );
endinterface

// File: rtl/nt_subckt_test_seq.sv
// LFSR-driven stimulus sequencer for one registered Nt-node subcircuit.
// Holds each vector LAT+1 cycles and compacts the output into a MISR.
module nt_subckt_test_seq #(
    parameter int               NIN   = 4,
    parameter int               LAT   = 2,
    parameter int               NVEC  = 16,
    parameter int               SIG_W = 16,
    parameter logic [15:0]      SEED  = 16'hACE1,
    parameter logic [SIG_W-1:0] POLY  = 'h1021
) (
    input  logic I1470_clk,
    input  logic I1477_rst,
    nt_subckt_test_seq_if.slave bus
);
    localparam int VW = $clog2(NVEC + 1);
    localparam int HW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      lfsr_q;
    logic [NIN-1:0]   din_q;
    logic [SIG_W-1:0] sig_q;
    logic [VW-1:0]    vidx_q;
    logic [HW-1:0]    hcnt_q;
    logic             pass_q;

    logic             capture;
    logic             last;
    logic             accept;
    logic [15:0]      lfsr_nxt;
    logic [SIG_W-1:0] sig_nxt;
    logic             busy;
    logic             done;

    assign capture = (state_q == HOLD) && (hcnt_q == HW'(LAT));
    assign last    = (vidx_q == VW'(NVEC - 1));
    assign accept  = bus.start && (state_q != HOLD);

    assign lfsr_nxt = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                       lfsr_q[15:1]};

    assign sig_nxt = {sig_q[SIG_W-2:0], 1'b0}
                   ^ ({SIG_W{sig_q[SIG_W-1]}} & POLY)
                   ^ SIG_W'(bus.dut_out);

    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = HOLD;
            HOLD:    if (capture && last) state_d = DONE;
            DONE:    if (bus.start) state_d = HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == HOLD);
        done = (state_q == DONE);
    end

    // Stimulus only moves on a vector boundary, so dut_in is a plain register.
    always_ff @(posedge I1470_clk or negedge I1477_rst) begin
        if (!I1477_rst) begin
            lfsr_q <= SEED;
            din_q  <= '0;
            sig_q  <= '0;
            vidx_q <= '0;
            hcnt_q <= '0;
            pass_q <= 1'b0;
        end else if (accept) begin
            lfsr_q <= SEED;
            din_q  <= SEED[NIN-1:0];
            sig_q  <= '0;
            vidx_q <= '0;
            hcnt_q <= '0;
            pass_q <= 1'b0;
        end else if (capture) begin
            sig_q <= sig_nxt;
            if (last) begin
                pass_q <= (sig_nxt == bus.golden_sig);
            end else begin
                vidx_q <= vidx_q + VW'(1);
                hcnt_q <= '0;
                lfsr_q <= lfsr_nxt;
                din_q  <= lfsr_nxt[NIN-1:0];
            end
        end else if (state_q == HOLD) begin
            hcnt_q <= hcnt_q + HW'(1);
        end
    end

    assign bus.dut_in  = din_q;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.pass    = done & pass_q;
    assign bus.sig     = sig_q;
    assign bus.vec_idx = vidx_q;
endmodule

// File: tb/tb_nt_subckt_test_seq.sv
// Bench for nt_subckt_test_seq: table of runs with a per-vector scoreboard,
// plus hand-written reset and restart sequences.
module tb_nt_subckt_test_seq;
    localparam int NIN   = 4;
    localparam int LAT   = 2;
    localparam int NVEC  = 4;
    localparam int SIG_W = 16;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] POLY = 16'h1021;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   mode = 0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    nt_subckt_test_seq_if #(.NIN(NIN), .SIG_W(SIG_W), .NVEC(NVEC)) bus ();

    nt_subckt_test_seq #(
        .NIN(NIN), .LAT(LAT), .NVEC(NVEC), .SIG_W(SIG_W)
    ) u_dut (
        .I1470_clk(clk),
        .I1477_rst(rst_n),
        .bus(bus.slave)
    );

    // Subcircuit stand-in: 0, 1, vector-index parity, or parity of dut_in.
    always_comb begin
        case (mode)
            1:       bus.dut_out = 1'b1;
            2:       bus.dut_out = bus.vec_idx[0];
            3:       bus.dut_out = ^bus.dut_in;
            default: bus.dut_out = 1'b0;
        endcase
    end

    typedef struct {
        int               mode;
        logic [SIG_W-1:0] golden;
        logic [SIG_W-1:0] exp_sig;
        bit               exp_pass;
        bit               mid_start;
    } run_t;

    typedef struct {
        logic [NIN-1:0]   din;
        logic [SIG_W-1:0] sig;
    } exp_t;

    run_t runs[5];
    exp_t sb[$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                    input logic b);
        logic [SIG_W-1:0] r;
        r = s << 1;
        if (s[SIG_W-1]) r = r ^ POLY;
        r[0] = r[0] ^ b;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic run(input run_t r);
        logic [15:0]      l;
        logic [SIG_W-1:0] s;
        logic [SIG_W-1:0] prev;
        logic             b;
        logic             was_done;
        exp_t             e;
        mode = r.mode;
        bus.golden_sig = r.golden;
        l = SEED;
        s = '0;
        for (int v = 0; v < NVEC; v++) begin
            case (r.mode)
                1:       b = 1'b1;
                2:       b = v[0];
                3:       b = ^l[NIN-1:0];
                default: b = 1'b0;
            endcase
            s = misr_step(s, b);
            sb.push_back('{din: l[NIN-1:0], sig: s});
            l = lfsr_step(l);
        end
        chk("idle_busy", bus.busy, 0);
        was_done = bus.done;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (was_done) chk("restart_done_drop", bus.done, 0);
        prev = '0;
        for (int v = 0; v < NVEC; v++) begin
            e = sb.pop_front();
            for (int c = 0; c <= LAT; c++) begin
                if (!(v == 0 && c == 0)) @(negedge clk);
                bus.start = (r.mid_start && v == 1 && c == 0);
                chk("busy", bus.busy, 1);
                chk("dut_in", bus.dut_in, e.din);
                chk("vec_idx", bus.vec_idx, v);
                if (c == 0) begin
                    chk("sig_step", bus.sig, prev);
                    chk("pass_low", bus.pass, 0);
                    chk("done_low", bus.done, 0);
                end
            end
            prev = e.sig;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("end_busy", bus.busy, 0);
        chk("done", bus.done, 1);
        chk("sig_model", bus.sig, prev);
        chk("sig_final", bus.sig, r.exp_sig);
        chk("pass", bus.pass, r.exp_pass);
        @(negedge clk);
        chk("done_hold", bus.done, 1);
        chk("pass_hold", bus.pass, r.exp_pass);
    endtask

    initial begin
        runs[0] = '{mode: 1, golden: 16'h000F, exp_sig: 16'h000F, exp_pass: 1, mid_start: 0};
        runs[1] = '{mode: 0, golden: 16'h000F, exp_sig: 16'h0000, exp_pass: 0, mid_start: 0};
        runs[2] = '{mode: 2, golden: 16'h0005, exp_sig: 16'h0005, exp_pass: 1, mid_start: 1};
        runs[3] = '{mode: 3, golden: 16'h000A, exp_sig: 16'h000A, exp_pass: 1, mid_start: 0};
        runs[4] = '{mode: 3, golden: 16'h000B, exp_sig: 16'h000A, exp_pass: 0, mid_start: 1};

        bus.start = 1'b0;
        bus.golden_sig = '0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_sig", bus.sig, 0);
        chk("rst_din", bus.dut_in, 0);
        chk("rst_vidx", bus.vec_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (runs[i]) run(runs[i]);

        // Abort mid-run: outputs clear immediately, no partial done afterwards.
        mode = 1;
        bus.golden_sig = 16'h000F;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        chk("mid_sig", bus.sig, 16'h0001);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_pass", bus.pass, 0);
        chk("abort_sig", bus.sig, 0);
        chk("abort_din", bus.dut_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_done", bus.done, 0);
        run(runs[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
